// File: rtl/dsp_be_align_pkg.sv
// Shared types and defaults for the backend input word aligner.
// Used by dsp_be_din_align and its peak detector.
package dsp_be_align_pkg;

    localparam int PRLL_RANK_DEF = 16;
    localparam int ADC_WIDTH_DEF = 6;
    localparam int LOCK_CNT_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        VERIFY = 2'd2,
        LOCKED = 2'd3
    } align_state_e;

    typedef logic signed [ADC_WIDTH_DEF-1:0] sample_t;

endpackage

// File: rtl/dsp_be_peak_detect.sv
// Flags a word holding exactly one sample at or above a signed threshold
// and reports that sample's index.
module dsp_be_peak_detect #(
    parameter int PRLL_RANK   = 16,
    parameter int ADC_WIDTH   = 6,
    parameter int SHIFT_WIDTH = $clog2(PRLL_RANK)
) (
    input  logic [PRLL_RANK*ADC_WIDTH-1:0] i_dat,
    input  logic signed [ADC_WIDTH-1:0]    i_thresh,
    output logic                           o_hit,
    output logic [SHIFT_WIDTH-1:0]         o_idx
);

    logic signed [ADC_WIDTH-1:0] smp;
    logic                        seen;
    logic                        multi;

    always_comb begin
        smp   = '0;
        seen  = 1'b0;
        multi = 1'b0;
        o_idx = '0;
        for (int k = 0; k < PRLL_RANK; k++) begin
            smp = i_dat[k*ADC_WIDTH +: ADC_WIDTH];
            if (smp >= i_thresh) begin
                multi = multi | seen;
                seen  = 1'b1;
                o_idx = SHIFT_WIDTH'(k);
            end
        end
    end

    // A second qualifying sample makes the peak ambiguous.
    assign o_hit = seen & ~multi;

endmodule

// File: rtl/dsp_be_din_align.sv
// Sample-level word aligner ahead of the backend EQ, manual or trained offset.
// Define DSP_BE_DIN_ALIGN_RELOCK_EN to drop lock after repeated peak moves.
module dsp_be_din_align
    import dsp_be_align_pkg::*;
#(
    parameter int PRLL_RANK     = PRLL_RANK_DEF,
    parameter int ADC_WIDTH     = ADC_WIDTH_DEF,
    parameter int LOCK_CNT      = LOCK_CNT_DEF,
    parameter int ERR_CNT_WIDTH = 8,
    parameter int SHIFT_WIDTH   = $clog2(PRLL_RANK)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [PRLL_RANK*ADC_WIDTH-1:0] i_dat,
    input  logic                           i_cfg_auto_en,
    input  logic [SHIFT_WIDTH-1:0]         i_cfg_shift,
    input  logic signed [ADC_WIDTH-1:0]    i_cfg_thresh,
    input  logic                           i_train_start,
    output logic [PRLL_RANK*ADC_WIDTH-1:0] o_dat_be,
    output logic [SHIFT_WIDTH-1:0]         o_shift,
    output logic                           o_locked,
    output logic [1:0]                     o_state,
    output logic [ERR_CNT_WIDTH-1:0]       o_err_cnt
);

    localparam int DW    = PRLL_RANK * ADC_WIDTH;
    localparam int CNT_W = $clog2(LOCK_CNT) + 1;

    logic [DW-1:0]            cur_q;
    logic [DW-1:0]            prev_q;
    logic [DW-1:0]            dat_q;
    logic [DW-1:0]            dat_d;
    logic [2*DW-1:0]          win_sh;
    logic [SHIFT_WIDTH-1:0]   shift_q;
    logic [SHIFT_WIDTH-1:0]   shift_d;
    logic [SHIFT_WIDTH-1:0]   cand_q;
    logic [SHIFT_WIDTH-1:0]   cand_d;
    logic [SHIFT_WIDTH-1:0]   pk_idx;
    logic                     pk_hit;
    logic                     locked_q;
    logic                     locked_d;
    align_state_e             state_q;
    align_state_e             state_d;
    logic [ERR_CNT_WIDTH-1:0] err_q;
    logic [ERR_CNT_WIDTH-1:0] err_d;
    logic [ERR_CNT_WIDTH-1:0] err_sat;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;
    logic                     match;

    // Window is {newer, older}; sample k of the output is window sample k+shift.
    assign win_sh = {cur_q, prev_q} >> (ADC_WIDTH * int'(shift_q));
    assign dat_d  = win_sh[DW-1:0];

    dsp_be_peak_detect #(
        .PRLL_RANK   (PRLL_RANK),
        .ADC_WIDTH   (ADC_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_peak (
        .i_dat    (cur_q),
        .i_thresh (i_cfg_thresh),
        .o_hit    (pk_hit),
        .o_idx    (pk_idx)
    );

    assign match   = pk_hit && (pk_idx == cand_q);
    assign err_sat = (&err_q) ? err_q : err_q + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cur_q  <= '0;
            prev_q <= '0;
            dat_q  <= '0;
        end else begin
            cur_q  <= i_dat;
            prev_q <= cur_q;
            dat_q  <= dat_d;
        end
    end

    // In LOCKED, cnt_q is reused as the consecutive peak-mismatch count.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        locked_d = locked_q;
        err_d    = err_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        if (!i_cfg_auto_en) begin
            state_d  = IDLE;
            shift_d  = i_cfg_shift;
            locked_d = 1'b0;
            cnt_d    = '0;
        end else if (i_train_start) begin
            if (state_q == IDLE) begin
                shift_d = i_cfg_shift;
            end
            state_d  = SEARCH;
            err_d    = '0;
            locked_d = 1'b0;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    shift_d = i_cfg_shift;
                end
                SEARCH: begin
                    if (pk_hit) begin
                        cand_d  = pk_idx;
                        cnt_d   = CNT_W'(1);
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (match) begin
                        if (cnt_q == CNT_W'(LOCK_CNT - 1)) begin
                            state_d  = LOCKED;
                            shift_d  = cand_q;
                            locked_d = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        err_d   = err_sat;
                        cnt_d   = '0;
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
`ifdef DSP_BE_DIN_ALIGN_RELOCK_EN
                    if (pk_hit && (pk_idx != shift_q)) begin
                        if (cnt_q == CNT_W'(LOCK_CNT - 1)) begin
                            cnt_d    = '0;
                            locked_d = 1'b0;
                            err_d    = err_sat;
                            state_d  = SEARCH;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (pk_hit) begin
                        cnt_d = '0;
                    end
`endif
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            locked_q <= 1'b0;
            err_q    <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_dat_be  = dat_q;
    assign o_shift   = shift_q;
    assign o_locked  = locked_q;
    assign o_state   = state_q;
    assign o_err_cnt = err_q;

endmodule

// File: tb/tb_dsp_be_din_align.sv
// Directed bench for dsp_be_din_align with a sample-stream reference model.
// Build with DSP_BE_DIN_ALIGN_RELOCK_EN defined to cover the relock option.
module tb_dsp_be_din_align;

    localparam int R  = 16;
    localparam int A  = 6;
    localparam int L  = 8;
    localparam int EW = 8;
    localparam int SW = 4;
    localparam int DW = R * A;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [DW-1:0]       din;
    logic                auto_en;
    logic [SW-1:0]       cfg_shift;
    logic signed [A-1:0] thresh;
    logic                start;
    logic [DW-1:0]       dat_be;
    logic [SW-1:0]       shift;
    logic                locked;
    logic [1:0]          state;
    logic [EW-1:0]       err;

    int total = 0;
    int bad   = 0;

    int stream[$];
    int m_out[R];
    int m_state, m_shift, m_locked, m_err, m_cand, m_run, m_mm;
    logic [DW-1:0] exp_dat;

    dsp_be_din_align #(
        .PRLL_RANK     (R),
        .ADC_WIDTH     (A),
        .LOCK_CNT      (L),
        .ERR_CNT_WIDTH (EW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_dat         (din),
        .i_cfg_auto_en (auto_en),
        .i_cfg_shift   (cfg_shift),
        .i_cfg_thresh  (thresh),
        .i_train_start (start),
        .o_dat_be      (dat_be),
        .o_shift       (shift),
        .o_locked      (locked),
        .o_state       (state),
        .o_err_cnt     (err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_peak(input int i1, input int i2);
        logic [DW-1:0] w;
        int v;
        w = '0;
        for (int k = 0; k < R; k++) begin
            v = -(k % 4);
            if (k == i1 || k == i2) v = 31;
            w[k*A +: A] = A'(v);
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] mk_ramp(input int j);
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < R; k++) w[k*A +: A] = A'((j * R + k) % 32);
        return w;
    endfunction

    // Reference: raw samples as one flat stream, preceded by two zero words.
    task automatic model_reset();
        stream.delete();
        for (int i = 0; i < 2 * R; i++) stream.push_back(0);
        for (int k = 0; k < R; k++) m_out[k] = 0;
        m_state = 0; m_shift = 0; m_locked = 0; m_err = 0;
        m_cand = 0; m_run = 0; m_mm = 0;
    endtask

    task automatic model_step();
        int w, nq, pidx, st;
        logic hit;
        w = stream.size() / R;
        for (int k = 0; k < R; k++) m_out[k] = stream[(w-2)*R + k + m_shift];
        nq = 0;
        pidx = 0;
        for (int k = 0; k < R; k++) begin
            if (stream[(w-1)*R + k] >= int'(thresh)) begin
                nq++;
                pidx = k;
            end
        end
        hit = (nq == 1);
        st = m_state;
        if (!auto_en) begin
            m_state = 0; m_shift = int'(cfg_shift); m_locked = 0;
            m_run = 0; m_mm = 0;
        end else if (start) begin
            if (st == 0) m_shift = int'(cfg_shift);
            m_state = 1; m_err = 0; m_locked = 0; m_run = 0; m_mm = 0;
        end else if (st == 0) begin
            m_shift = int'(cfg_shift);
        end else if (st == 1) begin
            if (hit) begin
                m_cand = pidx; m_run = 1; m_state = 2;
            end
        end else if (st == 2) begin
            if (hit && pidx == m_cand) begin
                m_run++;
                if (m_run == L) begin
                    m_state = 3; m_shift = m_cand; m_locked = 1;
                end
            end else begin
                if (m_err < 255) m_err++;
                m_state = 1;
            end
        end else begin
`ifdef DSP_BE_DIN_ALIGN_RELOCK_EN
            if (hit && pidx != m_shift) begin
                m_mm++;
                if (m_mm == L) begin
                    m_mm = 0; m_locked = 0; m_state = 1;
                    if (m_err < 255) m_err++;
                end
            end else if (hit) begin
                m_mm = 0;
            end
`endif
        end
        for (int k = 0; k < R; k++) stream.push_back(int'($signed(din[k*A +: A])));
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        exp_dat = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int k = 0; k < R; k++) exp_dat[k*A +: A] = A'(m_out[k]);
                check("cyc_dat", dat_be, exp_dat);
                check("cyc_shift", shift, m_shift);
                check("cyc_state", state, m_state);
                check("cyc_locked", locked, m_locked);
                check("cyc_err", err, m_err);
            end
        end
    end

    task automatic step(input logic [DW-1:0] w);
        @(negedge clk);
        din = w;
        start = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
    endtask

    int lat;
    logic saw;
    logic fell;

    initial begin
        rst_n = 1'b1; din = '0; auto_en = 1'b0; cfg_shift = 4'd5;
        thresh = 6'sd20; start = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dat", dat_be, 0);
        check("rst_shift", shift, 0);
        check("rst_state", state, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;

        for (int j = 0; j < 4; j++) step(mk_ramp(j));
        @(negedge clk);
        check("man_s0", dat_be[A-1:0], 21);
        check("man_s15", dat_be[DW-1 -: A], 4);
        check("man_state", state, 0);
        check("man_shift", shift, 5);

        auto_en = 1'b1; cfg_shift = 4'd0;
        step(mk_peak(-1, -1));
        pulse_start();
        step(mk_peak(7, -1));
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (locked) begin
                lat = i;
                break;
            end
        end
        check("lock_latency", lat - 1, L);
        check("lock_shift", shift, 7);
        check("lock_state", state, 3);
        @(negedge clk);
        check("lock_peak_s0", dat_be[A-1:0], 31);

        step(mk_peak(-1, -1));
        pulse_start();
        repeat (4) step(mk_peak(3, -1));
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(mk_peak(9, -1));
            if (state == 2'd1 && err == 8'd1) saw = 1'b1;
            if (locked) break;
        end
        check("vf_locked", locked, 1);
        check("vf_shift", shift, 9);
        check("vf_err", err, 1);
        check("vf_search_err", saw, 1);

        step(mk_peak(-1, -1));
        pulse_start();
        repeat (20) step(mk_peak(2, 11));
        check("amb_state", state, 1);
        check("amb_locked", locked, 0);
        check("amb_err", err, 0);

        step(mk_peak(-1, -1));
        pulse_start();
        repeat (3) step(mk_peak(4, -1));
        check("ovr_pre_state", state, 2);
        auto_en = 1'b0; start = 1'b1; cfg_shift = 4'd12;
        @(negedge clk);
        check("ovr_state", state, 0);
        check("ovr_shift", shift, 12);
        start = 1'b0;

        auto_en = 1'b1; cfg_shift = 4'd0;
        step(mk_peak(-1, -1));
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            step(mk_peak(7, -1));
            if (locked) break;
        end
        check("rl_lock", locked, 1);
        check("rl_shift0", shift, 7);
        fell = 1'b0;
        repeat (3 * L + 4) begin
            step(mk_peak(2, -1));
            if (!locked) fell = 1'b1;
        end
`ifdef DSP_BE_DIN_ALIGN_RELOCK_EN
        check("rl_shift", shift, 2);
        check("rl_locked", locked, 1);
        check("rl_fell", fell, 1);
        check("rl_err", err, 1);
`else
        check("rl_shift", shift, 7);
        check("rl_locked", locked, 1);
        check("rl_fell", fell, 0);
        check("rl_err", err, 0);
`endif

        step(mk_peak(-1, -1));
        pulse_start();
        repeat (3) step(mk_peak(5, -1));
        check("rv_pre_state", state, 2);
        #1 rst_n = 1'b0;
        #1;
        check("rv_state", state, 0);
        check("rv_shift", shift, 0);
        check("rv_locked", locked, 0);
        check("rv_err", err, 0);
        check("rv_dat", dat_be, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(mk_peak(-1, -1));
        check("rv_idle", state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsp_be_din_align.md
Name: dsp_be_din_align

Overview:
- Sample-level word aligner directly upstream of the backend EQ. It consumes deserialized ADC words and produces the aligned PRLL_RANK x ADC_WIDTH word that drives the EQ data input.
- The ADC/deserializer word boundary is arbitrary after power-up. This block rotates it by a sample offset.
- The offset is either set manually through scan config or found automatically by a training-pattern lock FSM.

Parameters:
- PRLL_RANK, 16, samples per word
- ADC_WIDTH, 6, bits per sample (signed fxp6p0)
- LOCK_CNT, 8, consecutive matching training words required to lock (>=2)
- ERR_CNT_WIDTH, 8, width of saturating error counter
- SHIFT_WIDTH, $clog2(PRLL_RANK), offset width (derived)

Ports:
- i_clk  in  1  backend digital clock
- i_rst_n  in  1  async active-low reset
- i_dat  in  PRLL_RANK*ADC_WIDTH  raw deserialized word, sample 0 = oldest
- i_cfg_auto_en  in  1  1 = FSM-controlled offset; 0 = manual offset
- i_cfg_shift  in  SHIFT_WIDTH  manual offset
- i_cfg_thresh  in  ADC_WIDTH  signed training-peak threshold
- i_train_start  in  1  pulse; starts a search (auto mode only)
- o_dat_be  out  PRLL_RANK*ADC_WIDTH  aligned word to the EQ
- o_shift  out  SHIFT_WIDTH  offset currently applied
- o_locked  out  1  auto lock achieved
- o_state  out  2  FSM state encoding
- o_err_cnt  out  ERR_CNT_WIDTH  saturating verify-failure count

Behaviour:
- Reset: all registers clear; o_dat_be=0, o_shift=0, o_locked=0, o_state=IDLE, o_err_cnt=0. Reset is async assert, sync deassert (deassertion is handled externally).
- Datapath:
  - r_cur<=i_dat; r_prev<=r_cur.
  - Window W = {r_cur, r_prev}: indices 0..R-1 are r_prev, R..2R-1 are r_cur.
  - o_dat_be[k] <= W[k+o_shift] for k=0..R-1.
  - With shift=0, o_dat_be equals i_dat sampled 2 edges earlier (input sampled at edge n appears after edge n+2).
- Shift change: takes effect on the next output update. The one transitional word is allowed to be mixed; no bubble is inserted.
- Peak detect (combinational on r_cur):
  - hit when exactly one sample satisfies signed sample >= i_cfg_thresh; idx = its index.
  - Zero or more than one qualifying sample = no-hit.
- FSM states: IDLE=0, SEARCH=1, VERIFY=2, LOCKED=3.
  - IDLE: o_shift follows i_cfg_shift each cycle; o_locked=0. If i_cfg_auto_en=1 and i_train_start=1 -> SEARCH.
  - SEARCH: on hit, cand<=idx, cnt<=1 -> VERIFY. Otherwise stay. o_shift is held.
  - VERIFY:
    - hit with idx==cand: cnt++. When cnt reaches LOCK_CNT-1 and another match arrives -> LOCKED; o_shift<=cand; o_locked<=1.
    - hit with idx!=cand, or no-hit: err_cnt++ (saturate at all-ones) -> SEARCH.
  - LOCKED: o_shift held; o_locked=1. i_train_start -> SEARCH.
- Precedence and boundary cases:
  - i_cfg_auto_en=0 forces IDLE from any state in the next cycle. This overrides a simultaneous i_train_start.
  - i_train_start in any auto state -> SEARCH, err_cnt<=0, o_locked<=0, cnt<=0. o_shift keeps its last value until a new lock.
  - Peak at index 0 is valid and gives shift 0. The peak sample maps to o_dat_be sample 0 after lock.
  - Reset mid-VERIFY returns to IDLE with all counters cleared.

Optional Feature:
- Macro: DSP_BE_DIN_ALIGN_RELOCK_EN.
- Defined: in LOCKED, a hit with idx!=o_shift increments a mismatch counter. A hit with idx==o_shift clears it; no-hit leaves it unchanged. After LOCK_CNT consecutive mismatches: o_locked<=0, err_cnt++, -> SEARCH.
- Undefined: LOCKED holds until i_train_start, i_cfg_auto_en=0, or reset. The mismatch logic is absent.

Decomposition:
- Package dsp_be_align_pkg holds:
  - typedef enum logic [1:0] align_state_e {IDLE, SEARCH, VERIFY, LOCKED}
  - the sample type (logic signed [ADC_WIDTH-1:0])
  - default LOCK_CNT
- One sub-module, dsp_be_peak_detect: combinational unique-above-threshold detector returning hit and idx.

Test Plan:
- Manual: auto_en=0, shift=5, ramp input (sample k = k mod 32) -> o_dat_be[0] equals raw stream sample 5; o_state=0.
- Auto lock: auto_en=1, thresh=+20, peak +31 at idx 7 and others <=0 each word, pulse train_start -> o_locked=1 exactly LOCK_CNT words after the first hit; o_shift=7; o_dat_be[0]=+31.
- Verify fail: peak at idx 3 for 4 words, then at idx 9 -> state SEARCH then VERIFY; err_cnt=1; lock lands at shift 9.
- Ambiguous: two samples =+31 in every word -> FSM remains SEARCH; o_locked=0; err_cnt=0.
- Override: in VERIFY, drop auto_en together with a train_start pulse -> IDLE next cycle; o_shift=i_cfg_shift.
- Relock (macro defined): after lock at 7, move peak to 2 for LOCK_CNT words -> o_locked falls, then relocks with o_shift=2. Macro undefined: o_shift stays 7.
